// File: rtl/tmp_i2c_pkg.sv
// Shared types and register map for the temperature-sensor I2C responder.
package tmp_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  localparam logic [7:0] REG_TMSB = 8'h00;
  localparam logic [7:0] REG_TLSB = 8'h01;
  localparam logic [7:0] REG_CFG  = 8'h03;
  localparam logic [7:0] REG_ID   = 8'h0B;

  function automatic logic [7:0] reg_read(input logic [7:0]  ptr,
                                          input logic [15:0] snap,
                                          input logic [7:0]  cfg,
                                          input logic [7:0]  id);
    logic [7:0] val;
    val = 8'h00;
    case (ptr)
      REG_TMSB: val = snap[15:8];
      REG_TLSB: val = snap[7:0];
      REG_CFG:  val = cfg;
      REG_ID:   val = id;
      default:  val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/tmp_i2c_responder_if.sv
// I2C bus signals seen by the responder; sda_oe = 1 pulls SDA low.
interface tmp_i2c_responder_if;
  logic scl;
  logic sda_i;
  logic sda_oe;

  modport master (output scl, output sda_i, input sda_oe);
  modport slave  (input scl, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_cond_det.sv
// Synchronizes SCL/SDA into clk and flags SCL edges plus START/STOP conditions.
module i2c_cond_det (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic scl_m, scl_s, scl_d;
  logic sda_m, sda_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_d <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_m <= scl;
      scl_s <= scl_m;
      scl_d <= scl_s;
      sda_m <= sda;
      sda_s <= sda_m;
      sda_d <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  // SCL must be high on both samples so an SDA change around an SCL edge is not misread
  assign start = scl_s & scl_d & sda_d & ~sda_s;
  assign stop  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/tmp_i2c_responder.sv
// I2C target exposing a coherent temperature snapshot, a config register and an ID register.
module tmp_i2c_responder
  import tmp_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h4B,
  parameter logic [7:0] ID_VAL   = 8'hCB
) (
  input  logic                       clk,
  input  logic                       rst,
  tmp_i2c_responder_if.slave         bus,
  input  logic [12:0]                temp,
  output logic [7:0]                 cfg,
  output logic                       busy
);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_cond_det u_cond_det (
    .clk      (clk),
    .rst      (rst),
    .scl      (bus.scl),
    .sda      (bus.sda_i),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [6:0]  tx;
  logic [7:0]  pointer;
  logic [15:0] snapshot;
  logic        rw, ack_on, ptr_loaded, ld, sda_oe;
  logic [7:0]  rx_byte, rd_data;

  assign rx_byte    = {shreg, sda_s};
  assign rd_data    = reg_read(pointer, snapshot, cfg, ID_VAL);
  assign bus.sda_oe = sda_oe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx         <= '0;
      pointer    <= 8'h00;
      cfg        <= 8'h00;
      snapshot   <= '0;
      rw         <= 1'b0;
      ack_on     <= 1'b0;
      ptr_loaded <= 1'b0;
      ld         <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
    end else if (start) begin
      state   <= ADDR;
      bit_cnt <= '0;
      ack_on  <= 1'b0;
      ld      <= 1'b0;
      sda_oe  <= 1'b0;
    end else if (stop) begin
      state  <= IDLE;
      ack_on <= 1'b0;
      ld     <= 1'b0;
      sda_oe <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shreg   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (rx_byte[7:1] == DEV_ADDR) begin
              state      <= ADDR_ACK;
              rw         <= rx_byte[0];
              busy       <= 1'b1;
              ptr_loaded <= 1'b0;
              if (rx_byte[0]) snapshot <= {temp, 3'b000};
            end else begin
              state <= IGNORE;
            end
          end
        end
        // first falling edge opens the ACK bit, the second closes it
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!ack_on) begin
            ack_on <= 1'b1;
            sda_oe <= 1'b1;
          end else begin
            ack_on  <= 1'b0;
            bit_cnt <= '0;
            if (state == ADDR_ACK && rw) begin
              state  <= RD_BYTE;
              tx     <= rd_data[6:0];
              sda_oe <= ~rd_data[7];
            end else begin
              state  <= WR_BYTE;
              sda_oe <= 1'b0;
            end
          end
        end
        WR_BYTE: if (scl_rise) begin
          shreg   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= WR_ACK;
            if (!ptr_loaded) begin
              pointer    <= rx_byte;
              ptr_loaded <= 1'b1;
            end else begin
              if (pointer == REG_CFG) cfg <= rx_byte;
              pointer <= pointer + 8'd1;
            end
          end
        end
        // ld marks a byte that follows a master ACK and still has to be fetched
        RD_BYTE: if (scl_fall) begin
          if (ld) begin
            ld      <= 1'b0;
            bit_cnt <= '0;
            tx      <= rd_data[6:0];
            sda_oe  <= ~rd_data[7];
          end else if (bit_cnt == 3'd7) begin
            state  <= RD_ACK;
            sda_oe <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx      <= {tx[5:0], 1'b0};
            sda_oe  <= ~tx[6];
          end
        end
        RD_ACK: if (scl_rise) begin
          if (!sda_s) begin
            pointer <= pointer + 8'd1;
            state   <= RD_BYTE;
            ld      <= 1'b1;
          end else begin
            state <= IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/tmp_i2c_responder.md
TMP_I2C_RESPONDER -- requirements
Module: tmp_i2c_responder

Interface
REQ-001 Parameter DEV_ADDR, default 7'h4B: the 7-bit I2C device address this block answers to.
REQ-002 Parameter ID_VAL, default 8'hCB: the value returned by the ID register 0x0B.
REQ-003 clk  input  1  system clock; the block SHALL have one clock; clk SHALL run at least 16x the SCL frequency.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 scl  input  1  I2C clock from the bus master; asynchronous to clk.
REQ-006 sda_i  input  1  I2C data as sampled from the bus; asynchronous to clk.
REQ-007 sda_oe  output  1  open-drain enable; 1 = pull SDA low, 0 = release SDA; the top level builds the tristate.
REQ-008 temp  input  13  two's-complement temperature with 4 fractional bits, to be reported over the bus.
REQ-009 cfg  output  8  current content of the configuration register 0x03.
REQ-010 busy  output  1  high from an addressed START until the next STOP.

Function
REQ-011 scl and sda_i SHALL each pass through a 2-FF synchronizer; all edge detection SHALL use the synchronized values.
REQ-012 START = synchronized SDA falls while SCL is high; STOP = SDA rises while SCL is high; both SHALL be recognised in every state, including a repeated START.
REQ-013 FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-014 IDLE -> ADDR on START; ADDR shifts 8 bits MSB-first, sampling on SCL rising edges.
REQ-015 If the address matches DEV_ADDR, ADDR -> ADDR_ACK; if it does not match, ADDR -> IGNORE, and sda_oe SHALL stay 0.
REQ-016 In every ACK state driven by this block, sda_oe SHALL assert within 3 clk of the SCL falling edge and release within 3 clk of the next SCL falling edge.
REQ-017 Write path: the first data byte after a write address SHALL load the 8-bit pointer.
REQ-018 Each later write byte SHALL be stored at the pointer if pointer == 0x03, and discarded otherwise; it SHALL be ACKed in both cases; the pointer SHALL increment after each byte.
REQ-019 Read path: on address match with R/W = 1, the block SHALL snapshot {temp, 3'b000} into a 16-bit register, so that MSB and LSB are coherent.
REQ-020 Read data: RD_BYTE SHALL shift the byte at the pointer out MSB-first; SDA SHALL change only after an SCL falling edge.
REQ-021 Read register map: 0x00 = snapshot[15:8]; 0x01 = snapshot[7:0]; 0x03 = cfg; 0x0B = ID_VAL; any other pointer = 8'h00.
REQ-022 RD_ACK SHALL sample the master ACK on SCL rising: ACK -> increment the pointer, then RD_BYTE; NACK -> IGNORE, with SDA released.
REQ-023 IGNORE SHALL hold sda_oe = 0 and leave only on START (-> ADDR) or STOP (-> IDLE).
REQ-024 STOP in any state SHALL go to IDLE, release sda_oe, and keep the pointer and cfg; START in any state SHALL go to ADDR.
REQ-025 The pointer SHALL wrap from 8'hFF to 8'h00.

Reset
REQ-026 Asserting rst SHALL immediately (asynchronously) set state = IDLE, sda_oe = 0, busy = 0, pointer = 8'h00, cfg = 8'h00, snapshot = 0, and the synchronizers to 1.
REQ-027 Reset in the middle of a transfer SHALL release SDA at once; the block SHALL ignore the bus until the next START.

Structure
REQ-028 A shared package tmp_i2c_pkg SHALL hold the FSM state enum and the register-address constants REG_TMSB = 8'h00, REG_TLSB = 8'h01, REG_CFG = 8'h03, REG_ID = 8'h0B.
REQ-029 One sub-module, i2c_cond_det, SHALL contain the synchronizers and detection of SCL rise/fall, START and STOP.

Verification
REQ-030 temp = 13'h0190 (25.0 C): write address 0x96 with pointer 0x00, repeated START, read address 0x97, read 2 bytes (ACK then NACK) -> bytes 8'h0C, 8'h80; SDA released afterwards.
REQ-031 Write 0x96 with 0x03, 0x80, then read 0x03 -> 8'h80; cfg = 8'h80; the pointer has advanced to 0x04 after the write.
REQ-032 Address 0x90 (mismatch) -> sda_oe never asserts during the ACK slot; busy stays 0; the FSM is in IGNORE until STOP.
REQ-033 Pointer 0x0B, read -> 8'hCB; temp changes between the MSB and LSB bytes of a read -> the LSB still comes from the snapshot.
REQ-034 temp = 13'h1FF0 (-1.0 C) read -> bytes 8'hFF, 8'h80; reading past 0x01 returns 8'h00 at pointer 0x02.
REQ-035 Assert rst while sda_oe = 1 during a read -> sda_oe = 0 in the same cycle; the next transaction succeeds normally.
